// File: rtl/tanh_pkg.sv
// rtl/tanh_pkg.sv - S7.8 types, constants and rescale helper for tanh_backward.
// TANH_BWD_ROUND_EN selects round-half-up rescaling instead of floor truncation.
package tanh_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;

  typedef logic signed [DATA_WIDTH-1:0] s7p8_t;

  localparam s7p8_t FIX_ONE           = 16'sh0100;
  localparam s7p8_t GRAD_CLIP_DEFAULT = 16'sh0400;

  // Drops FRAC_BITS from a 32-bit S15.16-style product back to S7.8 scale.
  function automatic logic signed [31:0] fix_rescale(input logic signed [31:0] prod);
`ifdef TANH_BWD_ROUND_EN
    return (prod + (32'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
`else
    return prod >>> FRAC_BITS;
`endif
  endfunction

endpackage

// File: rtl/tanh_backward_if.sv
// rtl/tanh_backward_if.sv - element stream in/out, gradient out and saturation flag.
interface tanh_backward_if;
  import tanh_pkg::*;

  logic       in_valid;
  logic       in_ready;
  s7p8_t      y_in;
  s7p8_t      g_in;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  s7p8_t      dx_out;
  logic       out_last;
  logic [7:0] out_idx;
  logic       sat_clr;
  logic       sat_sticky;

  modport master (
    output in_valid, y_in, g_in, in_last, out_ready, sat_clr,
    input  in_ready, out_valid, dx_out, out_last, out_idx, sat_sticky
  );

  modport slave (
    input  in_valid, y_in, g_in, in_last, out_ready, sat_clr,
    output in_ready, out_valid, dx_out, out_last, out_idx, sat_sticky
  );
endinterface

// File: rtl/tanh_bwd_stage.sv
// rtl/tanh_bwd_stage.sv - one valid/ready pipeline register; loads when downstream moves or it is empty.
module tanh_bwd_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_next,
  input  logic         vld_in,
  input  logic [W-1:0] data_in,
  output logic         en,
  output logic         vld,
  output logic [W-1:0] data
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  assign en   = en_next | ~vld_q;
  assign vld  = vld_q;
  assign data = data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (en) begin
      vld_d  = vld_in;
      data_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/tanh_backward.sv
// rtl/tanh_backward.sv - dx = g * (1 - y^2) in S7.8, 3-stage valid/ready pipeline with clipping.
module tanh_backward
  import tanh_pkg::*;
#(
  parameter s7p8_t GRAD_CLIP = GRAD_CLIP_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  tanh_backward_if.slave  bus
);

  localparam logic signed [31:0] CLIP_POS = 32'(GRAD_CLIP);
  localparam logic signed [31:0] CLIP_NEG = -CLIP_POS;

  logic        en1, en2, en3;
  logic        v1, v2, v3;
  logic [32:0] s1_data, s2_data, s2_in;
  logic [16:0] s3_data, s3_in;

  s7p8_t y1, g1, g2, d2, d_c, dx_c;
  logic  last1, last2, clip_c;
  logic signed [31:0] sq, one_minus, p;

  assign {last1, y1, g1} = s1_data;
  assign {last2, g2, d2} = s2_data;

  always_comb begin
    sq        = fix_rescale(32'(y1) * 32'(y1));
    one_minus = 32'(FIX_ONE) - sq;
    d_c       = one_minus[DATA_WIDTH-1:0];
    if (one_minus < 0)             d_c = '0;
    else if (one_minus > 32'(FIX_ONE)) d_c = FIX_ONE;
  end

  always_comb begin
    p      = fix_rescale(32'(g2) * 32'(d2));
    dx_c   = p[DATA_WIDTH-1:0];
    clip_c = 1'b0;
    if (p > CLIP_POS) begin
      dx_c   = GRAD_CLIP;
      clip_c = 1'b1;
    end else if (p < CLIP_NEG) begin
      dx_c   = -GRAD_CLIP;
      clip_c = 1'b1;
    end
  end

  assign s2_in = {last1, g1, d_c};
  assign s3_in = {last2, dx_c};

  tanh_bwd_stage #(.W(33)) u_s1 (
    .clk(clk), .rst_n(rst_n), .en_next(en2), .vld_in(bus.in_valid),
    .data_in({bus.in_last, bus.y_in, bus.g_in}), .en(en1), .vld(v1), .data(s1_data)
  );

  tanh_bwd_stage #(.W(33)) u_s2 (
    .clk(clk), .rst_n(rst_n), .en_next(en3), .vld_in(v1),
    .data_in(s2_in), .en(en2), .vld(v2), .data(s2_data)
  );

  tanh_bwd_stage #(.W(17)) u_s3 (
    .clk(clk), .rst_n(rst_n), .en_next(bus.out_ready), .vld_in(v2),
    .data_in(s3_in), .en(en3), .vld(v3), .data(s3_data)
  );

  logic       sat_q, sat_d;
  logic [7:0] idx_q, idx_d;

  // Clear dominates a simultaneous saturation event.
  always_comb begin
    sat_d = sat_q;
    if (en3 && v2 && clip_c) sat_d = 1'b1;
    if (bus.sat_clr)         sat_d = 1'b0;
    idx_d = idx_q;
    if (v3 && bus.out_ready) idx_d = s3_data[16] ? 8'd0 : idx_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      idx_q <= 8'd0;
    end else begin
      sat_q <= sat_d;
      idx_q <= idx_d;
    end
  end

  assign bus.in_ready   = en1;
  assign bus.out_valid  = v3;
  assign bus.dx_out     = s3_data[15:0];
  assign bus.out_last   = s3_data[16];
  assign bus.out_idx    = idx_q;
  assign bus.sat_sticky = sat_q;

endmodule

// File: tb/tb_tanh_backward.sv
// tb/tb_tanh_backward.sv - directed self-checking bench for tanh_backward.
module tb_tanh_backward;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  tanh_backward_if bif ();

  tanh_backward dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

  always #5 clk = ~clk;

  task automatic test_reset;
    bif.in_valid = 1'b0; bif.y_in = '0; bif.g_in = '0; bif.in_last = 1'b0;
    bif.out_ready = 1'b1; bif.sat_clr = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bif.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bif.out_valid); else passed++;
    total++; if (bif.dx_out !== 16'h0000) $display("FAIL reset_dx got %h want 0000", bif.dx_out); else passed++;
    total++; if (bif.out_idx !== 8'd0) $display("FAIL reset_idx got %0d want 0", bif.out_idx); else passed++;
    total++; if (bif.sat_sticky !== 1'b0) $display("FAIL reset_sat got %b want 0", bif.sat_sticky); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bif.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bif.in_ready); else passed++;
  endtask

  // Single element with last=1; result must appear exactly three edges after acceptance.
  task automatic push_check(input logic [15:0] y, input logic [15:0] g, input logic [15:0] exp_dx, input string name);
    @(negedge clk);
    bif.in_valid = 1'b1; bif.y_in = y; bif.g_in = g; bif.in_last = 1'b1;
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(negedge clk);
    total++; if (bif.out_valid !== 1'b0) $display("FAIL %s_early got valid %b want 0", name, bif.out_valid); else passed++;
    @(negedge clk);
    total++; if (bif.out_valid !== 1'b1 || bif.dx_out !== exp_dx)
      $display("FAIL %s got valid %b dx %h want valid 1 dx %h", name, bif.out_valid, bif.dx_out, exp_dx); else passed++;
    total++; if (bif.out_last !== 1'b1 || bif.out_idx !== 8'd0)
      $display("FAIL %s_tag got last %b idx %0d want last 1 idx 0", name, bif.out_last, bif.out_idx); else passed++;
  endtask

  task automatic test_basic;
    push_check(16'h0000, 16'h0100, 16'h0100, "y0_g1");
    total++; if (bif.sat_sticky !== 1'b0) $display("FAIL basic_sat got %b want 0", bif.sat_sticky); else passed++;
    push_check(16'h0080, 16'h0200, 16'h0180, "y_half");
  endtask

  task automatic test_edges;
    push_check(16'h0100, 16'h0400, 16'h0000, "y_one");
    push_check(16'hFF00, 16'h0400, 16'h0000, "y_neg_one");
    push_check(16'h0200, 16'h0400, 16'h0000, "y_two_clamp");
    total++; if (bif.sat_sticky !== 1'b0) $display("FAIL edges_sat got %b want 0", bif.sat_sticky); else passed++;
  endtask

  task automatic test_clip;
    push_check(16'h0000, 16'h0800, 16'h0400, "clip_pos");
    total++; if (bif.sat_sticky !== 1'b1) $display("FAIL clip_sat_set got %b want 1", bif.sat_sticky); else passed++;
    push_check(16'h0000, 16'hF800, 16'hFC00, "clip_neg");
    @(negedge clk);
    bif.sat_clr = 1'b1;
    @(negedge clk);
    bif.sat_clr = 1'b0;
    total++; if (bif.sat_sticky !== 1'b0) $display("FAIL clip_sat_clr got %b want 0", bif.sat_sticky); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] g_tab [5];
    int icnt, ocnt, cyc;
    logic pend;
    for (int k = 0; k < 5; k++) g_tab[k] = 16'h0010 * 16'(k + 1);
    icnt = 0; ocnt = 0; pend = 1'b0;
    @(negedge clk);
    bif.y_in = 16'h0000; bif.g_in = g_tab[0]; bif.in_last = 1'b0; bif.in_valid = 1'b1;
    for (cyc = 0; cyc < 40 && ocnt < 5; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (pend) begin
          icnt++;
          if (icnt < 5) begin
            bif.g_in = g_tab[icnt]; bif.in_last = (icnt == 4);
          end else bif.in_valid = 1'b0;
        end
      end
      bif.out_ready = (cyc >= 6);
      #1;
      if (cyc == 5) begin
        total++; if (icnt !== 3) $display("FAIL stall_accepted got %0d want 3", icnt); else passed++;
        total++; if (bif.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", bif.in_ready); else passed++;
      end
      if (bif.out_valid && bif.out_ready) begin
        total++; if (bif.dx_out !== g_tab[ocnt] || bif.out_idx !== 8'(ocnt) || bif.out_last !== (ocnt == 4))
          $display("FAIL b2b_out%0d got dx %h idx %0d last %b want dx %h idx %0d last %b",
                   ocnt, bif.dx_out, bif.out_idx, bif.out_last, g_tab[ocnt], ocnt, (ocnt == 4));
        else passed++;
        ocnt++;
      end
      pend = bif.in_valid && bif.in_ready;
    end
    total++; if (ocnt !== 5) $display("FAIL b2b_count got %0d want 5", ocnt); else passed++;
    bif.in_valid = 1'b0; bif.out_ready = 1'b1;
  endtask

  task automatic test_midstream_reset;
    int stale;
    @(negedge clk);
    bif.in_valid = 1'b1; bif.y_in = 16'h0000; bif.g_in = 16'h0030; bif.in_last = 1'b0;
    @(negedge clk);
    bif.g_in = 16'h0040;
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(negedge clk);
    total++; if (bif.out_valid !== 1'b1 || bif.dx_out !== 16'h0030)
      $display("FAIL rst_pre got valid %b dx %h want valid 1 dx 0030", bif.out_valid, bif.dx_out); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bif.out_valid !== 1'b0 || bif.dx_out !== 16'h0000 || bif.out_idx !== 8'd0)
      $display("FAIL rst_async got valid %b dx %h idx %0d want 0 0000 0", bif.out_valid, bif.dx_out, bif.out_idx); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bif.out_valid) stale++;
    end
    total++; if (stale !== 0) $display("FAIL rst_stale got %0d outputs want 0", stale); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_clip();
    test_back_to_back();
    test_midstream_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
